// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared state, digit types and constants for the round timer.
//   state_t  : IDLE / RUN / PAUSE / EXPIRED
//   bcd_t    : one BCD digit
//   bin2bcd  : converts a 0..99 integer into packed {tens, ones} BCD
package game_timer_pkg;
    localparam int CS_PER_SEC = 100;
    localparam int CS_W       = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_EXPIRED
    } state_t;

    typedef logic [3:0] bcd_t;

    function automatic logic [7:0] bin2bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction
endpackage

// File: rtl/bcd2_down.sv
// bcd2_down: two-digit BCD down-counter with clear, load and zero flag.
//   i_clk, i_reset      : clock, asynchronous active-high reset
//   i_clear             : force 00 (highest priority)
//   i_load, i_load_val  : load packed {tens, ones}
//   i_dec               : decrement by one; holds at 00
//   o_tens, o_ones      : current digits
//   o_zero              : both digits are 0
module bcd2_down
    import game_timer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_zero
);
    bcd_t r_tens;
    bcd_t r_ones;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (i_clear) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (i_load) begin
            {r_tens, r_ones} <= i_load_val;
        end else if (i_dec && !o_zero) begin
            // ones borrow from tens when wrapping 0 -> 9
            r_ones <= (r_ones == 4'd0) ? 4'd9 : r_ones - 4'd1;
            if (r_ones == 4'd0)
                r_tens <= r_tens - 4'd1;
        end
    end

    assign o_tens = r_tens;
    assign o_ones = r_ones;
    assign o_zero = (r_tens == 4'd0) && (r_ones == 4'd0);
endmodule

// File: rtl/round_timer.sv
// round_timer: game-round countdown driven by an upstream centisecond count.
//   i_clk, i_reset      : 50 MHz clock, asynchronous active-high reset
//   i_cs_count          : centisecond count from system_clock; every change is one tick
//   i_start             : strobe, load ROUND_SECONDS and run
//   i_pause_toggle      : strobe, RUN <-> PAUSE
//   i_abort             : strobe, back to IDLE with cleared digits
//   o_secs_tens/ones    : BCD seconds remaining
//   o_centis            : centiseconds remaining in the current second (binary)
//   o_running/o_expired : state flags
//   o_expire_pulse      : one cycle on RUN -> EXPIRED
//   o_spawn_pulse       : one cycle every SPAWN_PERIOD_CS ticks while running
module round_timer
    import game_timer_pkg::*;
#(
    parameter int unsigned ROUND_SECONDS   = 60,
    parameter int unsigned SPAWN_PERIOD_CS = 75
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [CS_W-1:0] i_cs_count,
    input  logic            i_start,
    input  logic            i_pause_toggle,
    input  logic            i_abort,
    output logic [3:0]      o_secs_tens,
    output logic [3:0]      o_secs_ones,
    output logic [6:0]      o_centis,
    output logic            o_running,
    output logic            o_expired,
    output logic            o_expire_pulse,
    output logic            o_spawn_pulse
);
    localparam logic [7:0] ROUND_BCD  = bin2bcd(ROUND_SECONDS);
    localparam logic [9:0] SPAWN_LAST = 10'(SPAWN_PERIOD_CS - 1);
    localparam logic [6:0] CS_LAST    = 7'(CS_PER_SEC - 1);

    state_t          r_state;
    logic [CS_W-1:0] r_prev_cs;
    logic            r_primed;
    logic [6:0]      r_centis;
    logic [9:0]      r_spawn_cnt;
    logic            r_expire_pulse;
    logic            r_spawn_pulse;

    logic w_tick;
    logic w_run_tick;
    logic w_sec_dec;
    logic w_expire;
    logic w_spawn_hit;
    logic w_zero;

    // primed keeps the first post-reset cycle from seeing a change against the
    // cleared prev_cs register
    assign w_tick      = r_primed && (i_cs_count != r_prev_cs);
    // a tick only counts when no higher-priority command arrives in the same cycle
    assign w_run_tick  = w_tick && (r_state == ST_RUN) && !i_abort && !i_start && !i_pause_toggle;
    assign w_sec_dec   = w_run_tick && (r_centis == 7'd0);
    // 00.01 -> 00.00 is the expiring tick
    assign w_expire    = w_run_tick && (r_centis == 7'd1) && w_zero;
    assign w_spawn_hit = w_run_tick && !w_expire && (r_spawn_cnt == SPAWN_LAST);

    bcd2_down u_secs (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (i_abort),
        .i_load     (i_start),
        .i_load_val (ROUND_BCD),
        .i_dec      (w_sec_dec),
        .o_tens     (o_secs_tens),
        .o_ones     (o_secs_ones),
        .o_zero     (w_zero)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_prev_cs <= '0;
            r_primed  <= 1'b0;
        end else begin
            r_prev_cs <= i_cs_count;
            r_primed  <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_centis       <= '0;
            r_spawn_cnt    <= '0;
            r_expire_pulse <= 1'b0;
            r_spawn_pulse  <= 1'b0;
        end else begin
            r_expire_pulse <= w_expire;
            r_spawn_pulse  <= w_spawn_hit;
            if (i_abort) begin
                r_state     <= ST_IDLE;
                r_centis    <= '0;
                r_spawn_cnt <= '0;
            end else if (i_start) begin
                r_state     <= ST_RUN;
                r_centis    <= '0;
                r_spawn_cnt <= '0;
            end else if (i_pause_toggle) begin
                if (r_state == ST_RUN)
                    r_state <= ST_PAUSE;
                else if (r_state == ST_PAUSE)
                    r_state <= ST_RUN;
            end else if (w_run_tick) begin
                r_centis <= (r_centis == 7'd0) ? CS_LAST : r_centis - 7'd1;
                if (w_expire)
                    r_state <= ST_EXPIRED;
                else
                    r_spawn_cnt <= w_spawn_hit ? 10'd0 : r_spawn_cnt + 10'd1;
            end
        end
    end

    assign o_centis       = r_centis;
    assign o_running      = (r_state == ST_RUN);
    assign o_expired      = (r_state == ST_EXPIRED);
    assign o_expire_pulse = r_expire_pulse;
    assign o_spawn_pulse  = r_spawn_pulse;
endmodule

// File: tb/tb_round_timer.sv
// tb_round_timer: directed and randomized checks of round_timer against a remaining-time model.
module tb_round_timer;
    localparam int RS = 60;
    localparam int SP = 75;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] cs_count = 20'd12345;
    logic        start = 1'b0, pause_toggle = 1'b0, abort = 1'b0;
    logic [3:0]  secs_tens, secs_ones;
    logic [6:0]  centis;
    logic        running, expired, expire_pulse, spawn_pulse;

    int vectors = 0;
    int miscompares = 0;

    // model: remaining time as a plain centisecond count, spawn as ticks since last spawn
    int          m_state = M_IDLE;
    int          m_rem = 0;
    int          m_spawn = 0;
    bit          m_primed = 1'b0;
    bit          m_exp_p = 1'b0;
    bit          m_spawn_p = 1'b0;
    logic [19:0] m_prev = '0;
    int          n_exp = 0;
    int          n_spawn = 0;
    logic [19:0] cs = 20'd12345;

    round_timer #(.ROUND_SECONDS(RS), .SPAWN_PERIOD_CS(SP)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_cs_count     (cs_count),
        .i_start        (start),
        .i_pause_toggle (pause_toggle),
        .i_abort        (abort),
        .o_secs_tens    (secs_tens),
        .o_secs_ones    (secs_ones),
        .o_centis       (centis),
        .o_running      (running),
        .o_expired      (expired),
        .o_expire_pulse (expire_pulse),
        .o_spawn_pulse  (spawn_pulse)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        vectors++;
        chk("secs_tens", 20'(secs_tens), 20'((m_rem / 100) / 10));
        chk("secs_ones", 20'(secs_ones), 20'((m_rem / 100) % 10));
        chk("centis", 20'(centis), 20'(m_rem % 100));
        chk("running", 20'(running), 20'(m_state == M_RUN));
        chk("expired", 20'(expired), 20'(m_state == M_EXP));
        chk("expire_pulse", 20'(expire_pulse), 20'(m_exp_p));
        chk("spawn_pulse", 20'(spawn_pulse), 20'(m_spawn_p));
        if (expire_pulse === 1'b1) n_exp++;
        if (spawn_pulse === 1'b1) n_spawn++;
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_rem = 0;
        m_spawn = 0;
        m_primed = 1'b0;
        m_exp_p = 1'b0;
        m_spawn_p = 1'b0;
        m_prev = '0;
    endtask

    task automatic step(input bit st, input bit pt, input bit ab, input logic [19:0] c);
        bit tick;
        start = st;
        pause_toggle = pt;
        abort = ab;
        cs_count = c;
        tick = m_primed && (c != m_prev);
        m_exp_p = 1'b0;
        m_spawn_p = 1'b0;
        if (ab) begin
            m_state = M_IDLE;
            m_rem = 0;
            m_spawn = 0;
        end else if (st) begin
            m_state = M_RUN;
            m_rem = RS * 100;
            m_spawn = 0;
        end else if (pt) begin
            if (m_state == M_RUN) m_state = M_PAUSE;
            else if (m_state == M_PAUSE) m_state = M_RUN;
        end else if (tick && m_state == M_RUN) begin
            m_rem--;
            if (m_rem == 0) begin
                m_state = M_EXP;
                m_exp_p = 1'b1;
            end else begin
                m_spawn++;
                if (m_spawn == SP) begin
                    m_spawn = 0;
                    m_spawn_p = 1'b1;
                end
            end
        end
        m_primed = 1'b1;
        m_prev = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        pause_toggle = 1'b0;
        abort = 1'b0;
        check_all();
    endtask

    task automatic inc(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) step(1'b0, 1'b0, 1'b0, cs);
            cs = cs + 20'd1;
            step(1'b0, 1'b0, 1'b0, cs);
        end
    endtask

    initial begin
        // 1: reset with a nonzero count, then hold it
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();
        repeat (5) step(1'b0, 1'b0, 1'b0, cs);
        chk("idle_running", 20'(running), 20'd0);

        // 2: full round
        n_exp = 0;
        step(1'b1, 1'b0, 1'b0, cs);
        chk("start_tens", 20'(secs_tens), 20'd6);
        inc(100);
        chk("t2_tens", 20'(secs_tens), 20'd5);
        chk("t2_ones", 20'(secs_ones), 20'd9);
        chk("t2_centis", 20'(centis), 20'd0);
        chk("t2_running", 20'(running), 20'd1);
        inc(5900);
        chk("t2_exp_count", 20'(n_exp), 20'd1);
        chk("t2_expired", 20'(expired), 20'd1);
        repeat (4) step(1'b0, 1'b0, 1'b0, cs + 20'd1);
        chk("t2_hold_tens", 20'(secs_tens), 20'd0);

        // 3: spawn cadence
        step(1'b1, 1'b0, 1'b0, cs);
        n_spawn = 0;
        inc(300);
        chk("t3_spawn_count", 20'(n_spawn), 20'd4);
        chk("t3_tens", 20'(secs_tens), 20'd5);
        chk("t3_ones", 20'(secs_ones), 20'd7);

        // 4: pause at 42.17
        inc(1483);
        chk("t4_tens", 20'(secs_tens), 20'd4);
        chk("t4_ones", 20'(secs_ones), 20'd2);
        chk("t4_centis", 20'(centis), 20'd17);
        step(1'b0, 1'b1, 1'b0, cs);
        inc(500);
        step(1'b0, 1'b1, 1'b0, cs);
        chk("t4_resume_centis", 20'(centis), 20'd17);
        chk("t4_resume_running", 20'(running), 20'd1);
        inc(1);
        repeat (3) step(1'b0, 1'b0, 1'b0, cs);
        chk("t4_no_burst", 20'(centis), 20'd16);

        // 5: upstream wrap and start with a simultaneous tick
        step(1'b0, 1'b1, 1'b0, cs);
        cs = 20'd1000001;
        step(1'b0, 1'b0, 1'b0, cs);
        step(1'b0, 1'b1, 1'b0, cs);
        cs = 20'd0;
        step(1'b0, 1'b0, 1'b0, cs);
        step(1'b0, 1'b0, 1'b0, cs);
        chk("t5_wrap_centis", 20'(centis), 20'd15);
        cs = cs + 20'd1;
        step(1'b1, 1'b0, 1'b0, cs);
        chk("t5_start_tens", 20'(secs_tens), 20'd6);
        chk("t5_start_centis", 20'(centis), 20'd0);

        // 6: abort at 10.05, then async reset mid-round
        inc(4995);
        chk("t6_tens", 20'(secs_tens), 20'd1);
        chk("t6_ones", 20'(secs_ones), 20'd0);
        chk("t6_centis", 20'(centis), 20'd5);
        step(1'b0, 1'b0, 1'b1, cs);
        chk("t6_abort_running", 20'(running), 20'd0);
        chk("t6_abort_tens", 20'(secs_tens), 20'd0);
        chk("t6_exp_count", 20'(n_exp), 20'd1);
        step(1'b1, 1'b0, 1'b0, cs);
        inc(37);
        #4;
        reset = 1'b1;
        #3;
        model_reset();
        check_all();
        chk("t6_reset_running", 20'(running), 20'd0);
        cs = 20'd777;
        cs_count = cs;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, cs);

        // randomized commands and count changes
        for (int i = 0; i < 600; i++) begin
            bit st, pt, ab;
            st = ($urandom_range(0, 39) == 0);
            pt = ($urandom_range(0, 14) == 0);
            ab = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1) == 1) cs = cs + 20'd1;
            if ($urandom_range(0, 99) == 0) cs = 20'($urandom);
            step(st, pt, ab, cs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
